// File: rtl/alu_exec_if.sv
// Handshake bundle for the ALU execute stage: op/operand input stream,
// result output stream and the pipeline flush.
interface alu_exec_if #(
   parameter int TAG_W = 5
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_ctr;
   logic [31:0]      src_a;
   logic [31:0]      src_b;
   logic [4:0]       shamt;
   logic [TAG_W-1:0] in_tag;
   logic             in_wen;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      result;
   logic             zero;
   logic             overflow;
   logic [TAG_W-1:0] out_tag;
   logic             out_wen;

   modport slave (
      input  flush, in_valid, alu_ctr, src_a, src_b, shamt, in_tag, in_wen, out_ready,
      output in_ready, out_valid, result, zero, overflow, out_tag, out_wen
   );

   modport master (
      output flush, in_valid, alu_ctr, src_a, src_b, shamt, in_tag, in_wen, out_ready,
      input  in_ready, out_valid, result, zero, overflow, out_tag, out_wen
   );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered MIPS-style ALU execute stage with a 2-entry skid buffer between
// the combinational ALU and the writeback handshake.
module alu_exec_stage #(
   parameter int TAG_W    = 5,
   parameter bit OVF_KILL = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   alu_exec_if.slave  bus
);
   // Encoding is {out_valid, skid_valid}; 01 is unreachable.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      TWO   = 2'b11
   } buf_state_e;

   typedef struct packed {
      logic [31:0]      result;
      logic             zero;
      logic             overflow;
      logic [TAG_W-1:0] tag;
      logic             wen;
   } entry_t;

   buf_state_e  state_q, state_d;
   entry_t      out_q, out_d, skid_q, skid_d, new_entry;
   logic        in_ready_q;
   logic        xfer, pop;
   logic [31:0] sum, diff, res;
   logic        ovf;

   assign sum  = bus.src_a + bus.src_b;
   assign diff = bus.src_a - bus.src_b;

   always_comb begin
      // NOTE: every variable gets a default first so no case arm can leave it unassigned and infer a latch.
      res = '0;
      ovf = 1'b0;
      case (bus.alu_ctr)
         4'b0000: res = sum;
         4'b0001: begin
            res = sum;
            ovf = (bus.src_a[31] == bus.src_b[31]) && (sum[31] != bus.src_a[31]);
         end
         4'b0100: res = diff;
         4'b0101: begin
            res = diff;
            ovf = (bus.src_a[31] != bus.src_b[31]) && (diff[31] != bus.src_a[31]);
         end
         4'b0011: res = bus.src_a & bus.src_b;
         4'b0010: res = bus.src_a | bus.src_b;
         4'b1000: res = bus.src_a ^ bus.src_b;
         4'b0111: res = {31'd0, $signed(bus.src_a) < $signed(bus.src_b)};
         4'b0110: res = {31'd0, bus.src_a < bus.src_b};
         4'b1010: res = bus.src_b << bus.shamt;
         4'b1011: res = bus.src_b >> bus.shamt;
         4'b1101: res = $signed(bus.src_b) >>> bus.shamt;
         4'b1100: res = bus.src_b << bus.src_a[4:0];
         4'b1111: res = bus.src_b >> bus.src_a[4:0];
         4'b1110: res = $signed(bus.src_b) >>> bus.src_a[4:0];
         default: res = '0;
      endcase
   end

   // Reserved code 1001 falls through to res=0 and is never allowed to write back.
   assign new_entry = '{
      result:   res,
      zero:     (res == '0),
      overflow: ovf,
      tag:      bus.in_tag,
      wen:      bus.in_wen && !(ovf && OVF_KILL) && (bus.alu_ctr != 4'b1001)
   };

   assign bus.in_ready  = in_ready_q && !rst;
   assign bus.out_valid = (state_q != EMPTY);
   assign xfer          = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: if (xfer) begin
            state_d = ONE;
            out_d   = new_entry;
         end
         ONE: begin
            if (xfer && pop) begin
               out_d = new_entry;
            end else if (xfer) begin
               state_d = TWO;
               skid_d  = new_entry;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: if (pop) begin
            state_d = ONE;
            out_d   = skid_q;
         end
         default: state_d = EMPTY;
      endcase
      // Killed ops must not disturb the held data outputs.
      if (bus.flush) begin
         state_d = EMPTY;
         out_d   = out_q;
         skid_d  = skid_q;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      if (rst) begin
         state_q    <= EMPTY;
         out_q      <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         out_q      <= out_d;
         in_ready_q <= (state_d != TWO);
      end
   end

   // NOTE: skid storage is not reset; its contents are only used when the state says the skid is full.
   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end

   assign bus.result   = out_q.result;
   assign bus.zero     = out_q.zero;
   assign bus.overflow = out_q.overflow;
   assign bus.out_tag  = out_q.tag;
   assign bus.out_wen  = out_q.wen;
endmodule
